// File: rtl/operand_entry_if.sv
// Keypad/core bundle for the operand entry controller.
// The keypad and core drive the master side; the controller is the slave.
interface operand_entry_if #(
  parameter int W = 14
);
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] result;
  logic [W-1:0] first_digit;
  logic [W-1:0] second_digit;
  logic [1:0]   operation;
  logic         operands_valid;
  logic [W-1:0] entry_value;
  logic [1:0]   phase;

  modport master (
    output key_valid, key_code, result,
    input  first_digit, second_digit, operation,
    input  operands_valid, entry_value, phase
  );

  modport slave (
    input  key_valid, key_code, result,
    output first_digit, second_digit, operation,
    output operands_valid, entry_value, phase
  );
endinterface

// File: rtl/operand_entry.sv
// Keypad entry controller: builds two decimal operands and an op code,
// presents them to the arithmetic core and chains from the last result.
module operand_entry #(
  parameter int W          = 14,
  parameter int MAX_DIGITS = 4
) (
  input logic           clk,
  input logic           rst,
  operand_entry_if.slave bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    S_FIRST  = 2'b00,
    S_SECOND = 2'b01,
    S_DONE   = 2'b10,
    S_ILL    = 2'b11
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   first_q, first_d;
  logic [W-1:0]   second_q, second_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic is_dig, is_op, is_eq, is_clr, room;

  // operand*10 + digit, formed wide then cut back to W
  function automatic logic [W-1:0] mac(
    input logic [W-1:0] a,
    input logic [3:0]   dg
  );
    logic [W+3:0] p;
    p = {4'b0, a} * (W+4)'(10) + (W+4)'(dg);
    return p[W-1:0];
  endfunction

  // A=mul, B=add, C=sub
  function automatic logic [1:0] op_of(input logic [3:0] c);
    logic [1:0] o;
    o = 2'b00;
    case (c)
      4'hA:    o = 2'b00;
      4'hB:    o = 2'b01;
      4'hC:    o = 2'b10;
      default: o = 2'b00;
    endcase
    return o;
  endfunction

  assign is_dig = bus.key_code <= 4'd9;
  assign is_op  = (bus.key_code == 4'hA) ||
                  (bus.key_code == 4'hB) ||
                  (bus.key_code == 4'hC);
  assign is_eq  = bus.key_code == 4'hE;
  assign is_clr = bus.key_code == 4'hF;
  assign room   = cnt_q < CW'(MAX_DIGITS);

  // State register and operand registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FIRST;
      first_q  <= '0;
      second_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      second_q <= second_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  // Key decode and next-state logic
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    second_d = second_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    if (state_q == S_ILL) begin
      state_d  = S_FIRST;
      first_d  = '0;
      second_d = '0;
      op_d     = '0;
      cnt_d    = '0;
    end else if (bus.key_valid) begin
      unique case (1'b1)
        is_clr: begin
          state_d  = S_FIRST;
          first_d  = '0;
          second_d = '0;
          op_d     = '0;
          cnt_d    = '0;
        end
        is_dig: begin
          case (state_q)
            S_FIRST: if (room) begin
              first_d = mac(first_q, bus.key_code);
              cnt_d   = cnt_q + 1'b1;
            end
            S_SECOND: if (room) begin
              second_d = mac(second_q, bus.key_code);
              cnt_d    = cnt_q + 1'b1;
            end
            S_DONE: begin
              first_d  = W'(bus.key_code);
              second_d = '0;
              cnt_d    = CW'(1);
              state_d  = S_FIRST;
            end
            default: ;
          endcase
        end
        is_op: begin
          case (state_q)
            S_FIRST: begin
              op_d    = op_of(bus.key_code);
              cnt_d   = '0;
              state_d = S_SECOND;
            end
            S_SECOND: if (cnt_q == '0) begin
              op_d = op_of(bus.key_code);
            end
            S_DONE: begin
              first_d  = bus.result;
              second_d = '0;
              op_d     = op_of(bus.key_code);
              cnt_d    = '0;
              state_d  = S_SECOND;
            end
            default: ;
          endcase
        end
        is_eq: begin
          if (state_q == S_SECOND) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Display value follows the operand being edited, or the answer
  always_comb begin
    bus.entry_value = '0;
    case (state_q)
      S_FIRST:  bus.entry_value = first_q;
      S_SECOND: bus.entry_value = second_q;
      S_DONE:   bus.entry_value = bus.result;
      default:  bus.entry_value = '0;
    endcase
  end

  assign bus.first_digit    = first_q;
  assign bus.second_digit   = second_q;
  assign bus.operation      = op_q;
  assign bus.operands_valid = state_q == S_DONE;
  assign bus.phase          = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed vector bench for the keypad operand entry controller.
// Each record is one clock of stimulus with the outputs expected after it.
module tb_operand_entry;

  logic clk = 1'b0;
  logic rst;

  operand_entry_if #(.W(14)) bus ();

  operand_entry #(.W(14), .MAX_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        kv;
    logic [3:0]  code;
    logic [13:0] res;
    logic [13:0] ef;
    logic [13:0] es;
    logic [1:0]  eop;
    logic        ev;
    logic [1:0]  eph;
    logic [13:0] eent;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic v(
    input logic        r,
    input logic        kv,
    input logic [3:0]  code,
    input logic [13:0] res,
    input logic [13:0] ef,
    input logic [13:0] es,
    input logic [1:0]  eop,
    input logic        ev,
    input logic [1:0]  eph,
    input logic [13:0] eent
  );
    vec_t t;
    t.r = r; t.kv = kv; t.code = code; t.res = res;
    t.ef = ef; t.es = es; t.eop = eop; t.ev = ev;
    t.eph = eph; t.eent = eent;
    vq.push_back(t);
  endtask

  // key press with no reset
  task automatic k(
    input logic [3:0]  code,
    input logic [13:0] res,
    input logic [13:0] ef,
    input logic [13:0] es,
    input logic [1:0]  eop,
    input logic        ev,
    input logic [1:0]  eph,
    input logic [13:0] eent
  );
    v(1'b0, 1'b1, code, res, ef, es, eop, ev, eph, eent);
  endtask

  task automatic check_all(
    input string       name,
    input logic [13:0] ef,
    input logic [13:0] es,
    input logic [1:0]  eop,
    input logic        ev,
    input logic [1:0]  eph,
    input logic [13:0] eent
  );
    checks++;
    if (bus.first_digit !== ef || bus.second_digit !== es ||
        bus.operation !== eop || bus.operands_valid !== ev ||
        bus.phase !== eph || bus.entry_value !== eent) begin
      errors++;
      $display("FAIL %s: got f=%0d s=%0d op=%0d v=%0b ph=%0d ent=%0d want f=%0d s=%0d op=%0d v=%0b ph=%0d ent=%0d",
               name, bus.first_digit, bus.second_digit, bus.operation,
               bus.operands_valid, bus.phase, bus.entry_value,
               ef, es, eop, ev, eph, eent);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.result    = '0;

    // reset, then 123 + 45 =
    v(1, 0, 4'h0, 0,   0,   0,  0, 0, 0, 0);
    k(4'h1, 0,   1,   0,  0, 0, 0, 1);
    k(4'h2, 0,   12,  0,  0, 0, 0, 12);
    k(4'h3, 0,   123, 0,  0, 0, 0, 123);
    k(4'hB, 0,   123, 0,  1, 0, 1, 0);
    k(4'h4, 0,   123, 4,  1, 0, 1, 4);
    k(4'h5, 0,   123, 45, 1, 0, 1, 45);
    k(4'hE, 500, 123, 45, 1, 1, 2, 500);
    v(0, 0, 4'h3, 500, 123, 45, 1, 1, 2, 500);
    // five nines: the fifth is dropped
    k(4'h9, 0, 9,    0, 1, 0, 0, 9);
    k(4'h9, 0, 99,   0, 1, 0, 0, 99);
    k(4'h9, 0, 999,  0, 1, 0, 0, 999);
    k(4'h9, 0, 9999, 0, 1, 0, 0, 9999);
    k(4'h9, 0, 9999, 0, 1, 0, 0, 9999);
    k(4'hB, 0, 9999, 0, 1, 0, 1, 0);
    k(4'h1, 0, 9999, 1, 1, 0, 1, 1);
    k(4'hE, 168, 9999, 1, 1, 1, 2, 168);
    // chain from result 168: * 2 =
    k(4'hA, 168, 168, 0, 0, 0, 1, 0);
    k(4'h2, 168, 168, 2, 0, 0, 1, 2);
    k(4'hE, 170, 168, 2, 0, 1, 2, 170);
    // 7 B C replaces op; after a digit op keys are ignored
    k(4'h7, 0, 7, 0, 0, 0, 0, 7);
    k(4'hB, 0, 7, 0, 1, 0, 1, 0);
    k(4'hC, 0, 7, 0, 2, 0, 1, 0);
    k(4'h3, 0, 7, 3, 2, 0, 1, 3);
    k(4'hA, 0, 7, 3, 2, 0, 1, 3);
    // clear
    k(4'hF, 0, 0, 0, 0, 0, 0, 0);
    k(4'h5, 0, 5, 0, 0, 0, 0, 5);
    k(4'hB, 0, 5, 0, 1, 0, 1, 0);
    k(4'h6, 0, 5, 6, 1, 0, 1, 6);
    k(4'hF, 0, 0, 0, 0, 0, 0, 0);
    // reset beats a digit in the same cycle
    v(1, 1, 4'h4, 0, 0, 0, 0, 0, 0, 0);
    k(4'hD, 0, 0, 0, 0, 0, 0, 0);
    k(4'hE, 0, 0, 0, 0, 0, 0, 0);
    // op with no digits; second operand capped at four digits
    k(4'hC, 0, 0, 0,    2, 0, 1, 0);
    k(4'h1, 0, 0, 1,    2, 0, 1, 1);
    k(4'h2, 0, 0, 12,   2, 0, 1, 12);
    k(4'h3, 0, 0, 123,  2, 0, 1, 123);
    k(4'h4, 0, 0, 1234, 2, 0, 1, 1234);
    k(4'h5, 0, 0, 1234, 2, 0, 1, 1234);
    k(4'hE, 77, 0, 1234, 2, 1, 2, 77);
    k(4'hD, 77, 0, 1234, 2, 1, 2, 77);
    k(4'hE, 77, 0, 1234, 2, 1, 2, 77);
    // digit leaves S_DONE; '=' in S_FIRST is ignored
    k(4'h5, 0, 5, 0, 2, 0, 0, 5);
    k(4'hE, 0, 5, 0, 2, 0, 0, 5);

    foreach (vq[i]) begin
      @(negedge clk);
      rst           = vq[i].r;
      bus.key_valid = vq[i].kv;
      bus.key_code  = vq[i].code;
      bus.result    = vq[i].res;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].ef, vq[i].es, vq[i].eop,
                vq[i].ev, vq[i].eph, vq[i].eent);
    end

    // entry_value follows result combinationally while in S_DONE
    @(negedge clk);
    rst = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hB;
    bus.result    = 14'd0;
    @(negedge clk);
    bus.key_code  = 4'hE;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.result    = 14'd42;
    #1;
    check_all("done_res42", 5, 0, 1, 1, 2, 42);
    bus.result    = 14'd9876;
    #1;
    check_all("done_res9876", 5, 0, 1, 1, 2, 9876);
    // idle cycles hold the operands for the core
    repeat (3) @(posedge clk);
    #1;
    check_all("done_hold", 5, 0, 1, 1, 2, 9876);
    // op key chains the live result
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hC;
    @(posedge clk);
    #1;
    check_all("chain_live", 9876, 0, 2, 0, 1, 0);
    @(negedge clk);
    bus.key_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
